// File: rtl/branch_pkg.sv
// Shared types and helpers for the two-stage RV32 conditional-branch resolver.
package branch_pkg;

    localparam int BRU_DATA_WIDTH = 32;
    localparam int BRU_ADDR_WIDTH = 32;
    localparam int BRU_IMM_WIDTH  = 13;
    localparam int BRU_BHT_DEPTH  = 16;

    typedef enum logic [2:0] {
        BEQ  = 3'b000,
        BNE  = 3'b001,
        BLT  = 3'b100,
        BGE  = 3'b101,
        BLTU = 3'b110,
        BGEU = 3'b111
    } branch_type_e;

    // funct3 010/011 are the only encodings with no conditional branch behind them
    function automatic logic is_legal_branch(input logic [2:0] funct3);
        return funct3[2:1] != 2'b01;
    endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Issue-side and result-side valid/ready bundle of the branch resolver.
interface branch_resolve_unit_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int IMM_WIDTH  = 13
);
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_branch;
    logic [2:0]            in_type;
    logic [DATA_WIDTH-1:0] in_rs1;
    logic [DATA_WIDTH-1:0] in_rs2;
    logic [ADDR_WIDTH-1:0] in_pc;
    logic [IMM_WIDTH-1:0]  in_imm;
    logic                  in_pred_taken;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_taken;
    logic                  out_illegal;
    logic                  out_mispredict;
    logic [ADDR_WIDTH-1:0] out_redirect;

    modport master (
        output in_valid, in_branch, in_type, in_rs1, in_rs2, in_pc, in_imm, in_pred_taken, out_ready,
        input  in_ready, out_valid, out_taken, out_illegal, out_mispredict, out_redirect
    );

    modport slave (
        input  in_valid, in_branch, in_type, in_rs1, in_rs2, in_pc, in_imm, in_pred_taken, out_ready,
        output in_ready, out_valid, out_taken, out_illegal, out_mispredict, out_redirect
    );
endinterface

// File: rtl/bht_table.sv
// Table of 2-bit saturating branch counters, reset to weakly-not-taken, with
// a fetch lookup, a capture lookup and one update port. Reads return pre-update state.
module bht_table #(
    parameter  int BHT_DEPTH = 16,
    localparam int IDX_W     = $clog2(BHT_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] fetch_idx,
    output logic             fetch_taken,
    input  logic [IDX_W-1:0] capture_idx,
    output logic             capture_taken,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    logic [BHT_DEPTH-1:0] ctr_hi;

    generate
        for (genvar gi = 0; gi < BHT_DEPTH; gi++) begin : g_ctr
            logic [1:0] ctr_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    ctr_reg <= 2'b01;
                end else if (upd_en && upd_idx == IDX_W'(gi)) begin
                    if (upd_taken && ctr_reg != 2'b11) begin
                        ctr_reg <= ctr_reg + 2'd1;
                    end else if (!upd_taken && ctr_reg != 2'b00) begin
                        ctr_reg <= ctr_reg - 2'd1;
                    end
                end
            end

            assign ctr_hi[gi] = ctr_reg[1];
        end
    endgenerate

    assign fetch_taken   = ctr_hi[fetch_idx];
    assign capture_taken = ctr_hi[capture_idx];

endmodule

// File: rtl/branch_resolve_unit.sv
// Two-stage RV32 conditional-branch resolver: S1 registers operands, S2 registers outcome.
// Optional internal predictor table enabled by defining BRU_BHT_EN.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int DATA_WIDTH = BRU_DATA_WIDTH,
    parameter int ADDR_WIDTH = BRU_ADDR_WIDTH,
    parameter int IMM_WIDTH  = BRU_IMM_WIDTH,
    parameter int BHT_DEPTH  = BRU_BHT_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    branch_resolve_unit_if.slave  bus
`ifdef BRU_BHT_EN
    ,
    input  logic [ADDR_WIDTH-1:0] pred_pc,
    output logic                  pred_taken
`endif
);

    logic                  s1_v_reg, s2_v_reg;
    logic                  s1_branch_reg, s1_pred_reg;
    logic [2:0]            s1_type_reg;
    logic [DATA_WIDTH-1:0] s1_rs1_reg, s1_rs2_reg;
    logic [ADDR_WIDTH-1:0] s1_pc_reg;
    logic [IMM_WIDTH-1:0]  s1_imm_reg;

    logic                  s2_taken_reg, s2_illegal_reg, s2_mispredict_reg;
    logic [ADDR_WIDTH-1:0] s2_redirect_reg;

    logic                  s2_adv, in_fire, capture_pred;
    logic                  cond, legal, taken_c, illegal_c, mispredict_c;
    logic [ADDR_WIDTH-1:0] target_c, redirect_c;

    assign s2_adv      = !s2_v_reg || bus.out_ready;
    assign bus.in_ready = !rst && !flush && (!s1_v_reg || s2_adv);
    assign in_fire     = bus.in_valid && bus.in_ready;

`ifdef BRU_BHT_EN
    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic             s2_upd_reg;
    logic [IDX_W-1:0] s2_idx_reg;
    logic             in_pred_unused, pred_pc_unused;

    // The fetch-time prediction is superseded by the table read when the op is captured
    assign in_pred_unused = bus.in_pred_taken;
    assign pred_pc_unused = ^{pred_pc[ADDR_WIDTH-1:IDX_W+2], pred_pc[1:0]};

    bht_table #(.BHT_DEPTH(BHT_DEPTH)) u_bht (
        .clk           (clk),
        .rst           (rst),
        .fetch_idx     (pred_pc[IDX_W+1:2]),
        .fetch_taken   (pred_taken),
        .capture_idx   (bus.in_pc[IDX_W+1:2]),
        .capture_taken (capture_pred),
        .upd_en        (s2_v_reg && bus.out_ready && s2_upd_reg && !flush),
        .upd_idx       (s2_idx_reg),
        .upd_taken     (s2_taken_reg)
    );

    always_ff @(posedge clk) begin
        if (!flush && s1_v_reg && s2_adv) begin
            s2_upd_reg <= s1_branch_reg && legal;
            s2_idx_reg <= s1_pc_reg[IDX_W+1:2];
        end
    end
`else
    assign capture_pred = bus.in_pred_taken;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_reg <= 1'b0;
        end else if (flush) begin
            s1_v_reg <= 1'b0;
        end else if (in_fire) begin
            s1_v_reg <= 1'b1;
        end else if (s2_adv) begin
            s1_v_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire) begin
            s1_branch_reg <= bus.in_branch;
            s1_type_reg   <= bus.in_type;
            s1_rs1_reg    <= bus.in_rs1;
            s1_rs2_reg    <= bus.in_rs2;
            s1_pc_reg     <= bus.in_pc;
            s1_imm_reg    <= bus.in_imm;
            s1_pred_reg   <= capture_pred;
        end
    end

    always_comb begin
        cond = 1'b0;
        case (branch_type_e'(s1_type_reg))
            BEQ:     cond = s1_rs1_reg == s1_rs2_reg;
            BNE:     cond = s1_rs1_reg != s1_rs2_reg;
            BLT:     cond = $signed(s1_rs1_reg) <  $signed(s1_rs2_reg);
            BGE:     cond = $signed(s1_rs1_reg) >= $signed(s1_rs2_reg);
            BLTU:    cond = s1_rs1_reg <  s1_rs2_reg;
            BGEU:    cond = s1_rs1_reg >= s1_rs2_reg;
            default: cond = 1'b0;
        endcase
        legal        = is_legal_branch(s1_type_reg);
        taken_c      = s1_branch_reg && legal && cond;
        illegal_c    = s1_branch_reg && !legal;
        mispredict_c = s1_branch_reg && legal && (taken_c != s1_pred_reg);
        target_c     = s1_pc_reg + {{(ADDR_WIDTH-IMM_WIDTH){s1_imm_reg[IMM_WIDTH-1]}}, s1_imm_reg};
        redirect_c   = taken_c ? target_c : s1_pc_reg + ADDR_WIDTH'(4);
    end

    // Result registers only move on an S2 advance, which keeps them frozen under back-pressure
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_v_reg          <= 1'b0;
            s2_taken_reg      <= 1'b0;
            s2_illegal_reg    <= 1'b0;
            s2_mispredict_reg <= 1'b0;
            s2_redirect_reg   <= '0;
        end else begin
            if (flush) begin
                s2_v_reg <= 1'b0;
            end else if (s2_adv) begin
                s2_v_reg <= s1_v_reg;
            end
            if (!flush && s1_v_reg && s2_adv) begin
                s2_taken_reg      <= taken_c;
                s2_illegal_reg    <= illegal_c;
                s2_mispredict_reg <= mispredict_c;
                s2_redirect_reg   <= redirect_c;
            end
        end
    end

    assign bus.out_valid      = s2_v_reg;
    assign bus.out_taken      = s2_taken_reg;
    assign bus.out_illegal    = s2_illegal_reg;
    assign bus.out_mispredict = s2_mispredict_reg;
    assign bus.out_redirect   = s2_redirect_reg;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Randomized bench for branch_resolve_unit against an in-order queue model of the
// resolver; also exercises BRU_BHT_EN when that macro is defined.
module tb_branch_resolve_unit;
    import branch_pkg::*;

    localparam int BD = 16;

    typedef struct {
        logic        taken;
        logic        illegal;
        logic        mispred;
        logic        upd;
        logic [31:0] redirect;
        logic [31:0] pc;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    branch_resolve_unit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .IMM_WIDTH(13)) bus ();

`ifdef BRU_BHT_EN
    logic [31:0] pred_pc = 32'h0;
    logic        pred_taken;
`endif

    branch_resolve_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .IMM_WIDTH(13), .BHT_DEPTH(BD)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
`ifdef BRU_BHT_EN
        ,
        .pred_pc    (pred_pc),
        .pred_taken (pred_taken)
`endif
    );

    exp_t q[$];
    int   bht_m[BD];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   stall_cnt = 0;
    bit   rand_ready = 1'b0;
    bit   started = 1'b0, rst_prev = 1'b0, flush_prev = 1'b0, held_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int bidx(input logic [31:0] pc);
        return int'(pc[$clog2(BD)+1:2]);
    endfunction

    // Reference resolution straight from the ISA rules
    function automatic exp_t model(input logic br, input logic [2:0] ty, input logic [31:0] a,
                                   input logic [31:0] b, input logic [31:0] pc,
                                   input logic [12:0] imm, input logic pred);
        exp_t   e;
        logic   c;
        logic   legal;
        longint off;
        legal = !(ty == 3'b010 || ty == 3'b011);
        case (ty)
            3'b000:  c = (a == b);
            3'b001:  c = (a != b);
            3'b100:  c = ((a ^ 32'h8000_0000) <  (b ^ 32'h8000_0000));
            3'b101:  c = ((a ^ 32'h8000_0000) >= (b ^ 32'h8000_0000));
            3'b110:  c = (a < b);
            3'b111:  c = (a >= b);
            default: c = 1'b0;
        endcase
        off        = imm[12] ? longint'(imm) - 64'sd8192 : longint'(imm);
        e.taken    = br && legal && c;
        e.illegal  = br && !legal;
        e.mispred  = br && legal && (e.taken != pred);
        e.upd      = br && legal;
        e.pc       = pc;
        e.redirect = e.taken ? 32'(longint'(pc) + off) : 32'(longint'(pc) + 64'sd4);
        e.acc      = cyc;
        return e;
    endfunction

    always @(negedge clk) begin
        if (stall_cnt > 0) begin
            bus.out_ready = 1'b0;
            stall_cnt--;
        end else begin
            bus.out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Compare process: inputs and outputs are settled 1 time unit after the falling edge
    always @(negedge clk) begin
        exp_t e;
        bit   exp_ready, have_new;
        logic pred_used;
        #1;
        cyc++;
        exp_ready = !rst && !flush && (q.size() < 2 || bus.out_ready);
        if (started) begin
            if (rst_prev) begin
                chk("rst_out_valid", bus.out_valid, 0);
                chk("rst_out_taken", bus.out_taken, 0);
                chk("rst_out_illegal", bus.out_illegal, 0);
                chk("rst_out_mispredict", bus.out_mispredict, 0);
                chk("rst_out_redirect", bus.out_redirect, 0);
            end else if (flush_prev) begin
                chk("flush_out_valid", bus.out_valid, 0);
            end else if (held_prev) begin
                chk("hold_out_valid", bus.out_valid, 1);
            end
            chk("in_ready", bus.in_ready, exp_ready);
            if (bus.out_valid && !rst_prev) begin
                if (q.size() == 0) begin
                    chk("spurious_out_valid", bus.out_valid, 0);
                end else begin
                    chk("out_taken", bus.out_taken, q[0].taken);
                    chk("out_illegal", bus.out_illegal, q[0].illegal);
                    chk("out_mispredict", bus.out_mispredict, q[0].mispred);
                    chk("out_redirect", bus.out_redirect, q[0].redirect);
                    chk("latency_early", 32'(cyc >= q[0].acc + 2), 1);
                end
            end
`ifdef BRU_BHT_EN
            chk("pred_taken", pred_taken, bht_m[bidx(pred_pc)] >= 2);
`endif
        end
        if (rst) begin
            q.delete();
            foreach (bht_m[i]) bht_m[i] = 1;
        end else if (flush) begin
            q.delete();
        end else begin
            have_new = 1'b0;
            if (bus.in_valid && exp_ready) begin
`ifdef BRU_BHT_EN
                pred_used = bht_m[bidx(bus.in_pc)] >= 2;
`else
                pred_used = bus.in_pred_taken;
`endif
                e = model(bus.in_branch, bus.in_type, bus.in_rs1, bus.in_rs2, bus.in_pc, bus.in_imm, pred_used);
                have_new = 1'b1;
            end
            if (bus.out_valid && bus.out_ready && q.size() > 0) begin
                exp_t d;
                d = q.pop_front();
                $display("op pc=0x%08h taken=%0d illegal=%0d mispredict=%0d redirect=0x%08h",
                         d.pc, bus.out_taken, bus.out_illegal, bus.out_mispredict, bus.out_redirect);
                if (d.upd) begin
                    if (d.taken && bht_m[bidx(d.pc)] < 3) bht_m[bidx(d.pc)]++;
                    if (!d.taken && bht_m[bidx(d.pc)] > 0) bht_m[bidx(d.pc)]--;
                end
            end
            if (have_new) q.push_back(e);
        end
        rst_prev   = rst;
        flush_prev = flush;
        held_prev  = bus.out_valid && !bus.out_ready;
        if (rst) started = 1'b1;
    end

    task automatic drive(input logic br, input logic [2:0] ty, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic [12:0] imm, input logic pred);
        bus.in_branch     = br;
        bus.in_type       = ty;
        bus.in_rs1        = a;
        bus.in_rs2        = b;
        bus.in_pc         = pc;
        bus.in_imm        = imm;
        bus.in_pred_taken = pred;
    endtask

    // Present an op and hold it until in_ready is seen; the next rising edge accepts it
    task automatic send(input logic br, input logic [2:0] ty, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] pc, input logic [12:0] imm, input logic pred);
        int k;
        @(negedge clk);
        drive(br, ty, a, b, pc, imm, pred);
        bus.in_valid = 1'b1;
        #2;
        k = 0;
        while (!bus.in_ready && k < 50) begin
            @(negedge clk);
            #2;
            k++;
        end
        if (k >= 50) chk("accept_timeout", 0, 1);
    endtask

    // Hand-computed result expected exactly two cycles after the accept of the last send
    task automatic lit(input string name, input logic taken, input logic illegal, input logic misp,
                       input logic [31:0] redirect);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        #2;
        chk({name, "_valid"}, bus.out_valid, 1);
        chk({name, "_taken"}, bus.out_taken, taken);
        chk({name, "_illegal"}, bus.out_illegal, illegal);
`ifndef BRU_BHT_EN
        chk({name, "_mispredict"}, bus.out_mispredict, misp);
`endif
        chk({name, "_redirect"}, bus.out_redirect, redirect);
    endtask

    initial begin
        logic [31:0] r, pcr;
        logic [12:0] immr;
        int          k;
        bus.in_valid = 1'b0;
        drive(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 13'h0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        send(1'b1, BLT, 32'hFFFF_FFFF, 32'h1, 32'h100, 13'h1FF8, 1'b1);
        lit("blt_neg", 1'b1, 1'b0, 1'b0, 32'h0000_00F8);
        send(1'b1, BLTU, 32'hFFFF_FFFF, 32'h1, 32'h100, 13'h1FF8, 1'b0);
        lit("bltu_raw", 1'b0, 1'b0, 1'b0, 32'h0000_0104);
        send(1'b1, BGEU, 32'hFFFF_FFFF, 32'h1, 32'h100, 13'h1FF8, 1'b1);
        lit("bgeu_raw", 1'b1, 1'b0, 1'b0, 32'h0000_00F8);
        send(1'b1, 3'b010, 32'h5, 32'h5, 32'h200, 13'h0010, 1'b1);
        lit("illegal_010", 1'b0, 1'b1, 1'b0, 32'h0000_0204);
        send(1'b1, BNE, 32'h1234, 32'h1234, 32'h300, 13'h0020, 1'b1);
        lit("bne_mispred", 1'b0, 1'b0, 1'b1, 32'h0000_0304);
        send(1'b0, BEQ, 32'h7, 32'h7, 32'h400, 13'h0040, 1'b1);
        lit("passthru", 1'b0, 1'b0, 1'b0, 32'h0000_0404);
        send(1'b1, BEQ, 32'h1, 32'h2, 32'hFFFF_FFFC, 13'h0008, 1'b0);
        lit("pc4_wrap", 1'b0, 1'b0, 1'b0, 32'h0000_0000);
        send(1'b1, BEQ, 32'h9, 32'h9, 32'hFFFF_FFF0, 13'h0010, 1'b1);
        lit("target_wrap", 1'b1, 1'b0, 1'b0, 32'h0000_0000);

        // Back-to-back ops into a stalled consumer
        stall_cnt = 4;
        for (int i = 0; i < 4; i++) send(1'b1, BLT, 32'(i), 32'h2, 32'h500 + 32'(i * 4), 13'h0100, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (8) @(negedge clk);

        // Flush with both stages full and a new op on offer
        stall_cnt = 20;
        send(1'b1, BEQ, 32'h1, 32'h1, 32'h600, 13'h0040, 1'b0);
        send(1'b1, BNE, 32'h1, 32'h2, 32'h604, 13'h0040, 1'b0);
        @(negedge clk);
        flush = 1'b1;
        drive(1'b1, BEQ, 32'hA, 32'hA, 32'h700, 13'h0080, 1'b0);
        #2;
        chk("flush_in_ready", bus.in_ready, 0);
        @(negedge clk);
        flush = 1'b0;
        bus.in_valid = 1'b0;
        stall_cnt = 0;
        repeat (4) @(negedge clk);

        // Reset in the middle of traffic
        stall_cnt = 20;
        send(1'b1, BGE, 32'h3, 32'h1, 32'h800, 13'h0020, 1'b0);
        send(1'b1, BGE, 32'h1, 32'h3, 32'h804, 13'h0020, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        stall_cnt = 0;
        repeat (3) @(negedge clk);

`ifdef BRU_BHT_EN
        @(negedge clk);
        pred_pc = 32'h40;
        #2;
        chk("bht_init_pred", pred_taken, 0);
        for (int i = 0; i < 3; i++) begin
            send(1'b1, BEQ, 32'h5, 32'h5, 32'h40, 13'h0010, 1'b0);
            lit("bht_taken", 1'b1, 1'b0, 1'b0, 32'h0000_0050);
        end
        @(negedge clk);
        #2;
        chk("bht_sat_pred", pred_taken, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #2;
        chk("bht_rst_pred", pred_taken, 0);
`endif

        rand_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            flush = ($urandom_range(0, 39) == 0);
            bus.in_valid = ($urandom_range(0, 3) != 0);
            r = $urandom;
            case ($urandom_range(0, 3))
                0:       pcr = 32'hFFFF_FFFC;
                1:       pcr = 32'h40 + 32'($urandom_range(0, 15) * 4);
                default: pcr = $urandom & 32'hFFFF_FFFC;
            endcase
            immr = 13'($urandom) & 13'h1FFE;
            drive($urandom_range(0, 7) != 0, 3'($urandom_range(0, 7)), r,
                  ($urandom_range(0, 3) == 0) ? r : (($urandom_range(0, 3) == 0) ? (r ^ 32'h8000_0000) : $urandom),
                  pcr, immr, 1'($urandom_range(0, 1)));
`ifdef BRU_BHT_EN
            pred_pc = 32'h40 + 32'($urandom_range(0, 15) * 4);
`endif
        end

        @(negedge clk);
        flush = 1'b0;
        bus.in_valid = 1'b0;
        rand_ready = 1'b0;
        k = 0;
        while (q.size() > 0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        #2;
        chk("drain_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
